// File: rtl/rns_forward_converter_1025_1024_1023_if.sv
// Valid/ready bundle for the binary-to-RNS forward converter.
// The slave side is the converter; the master side feeds x_in and drains the residues.
interface rns_forward_converter_1025_1024_1023_if #(
  parameter int N = 10
);
  logic [3*N-1:0] x_in;
  logic           in_valid_in;
  logic           in_ready_out;
  logic [N:0]     r1_out;
  logic [N-1:0]   r2_out;
  logic [N-1:0]   r3_out;
  logic           range_err_out;
  logic           out_valid_out;
  logic           out_ready_in;

  modport slave (
    input  x_in, in_valid_in, out_ready_in,
    output in_ready_out, r1_out, r2_out, r3_out, range_err_out, out_valid_out
  );

  modport master (
    output x_in, in_valid_in, out_ready_in,
    input  in_ready_out, r1_out, r2_out, r3_out, range_err_out, out_valid_out
  );
endinterface

// File: rtl/rns_forward_converter_1025_1024_1023.sv
// Two-stage binary-to-RNS converter for {2^N+1, 2^N, 2^N-1} with full backpressure.
// Stage 1 forms partial sums of the N-bit digits; stage 2 reduces them into range.
module rns_forward_converter_1025_1024_1023 #(
  parameter int N = 10
) (
  input  logic clk,
  input  logic rst,
  rns_forward_converter_1025_1024_1023_if.slave io
);
  localparam int XW = 3 * N;
  localparam logic [XW-1:0] RANGE_M =
    XW'(((64'd1 << N) + 64'd1) * (64'd1 << N) * ((64'd1 << N) - 64'd1));
  localparam logic signed [N+2:0] MOD1 = $signed((N+3)'((64'd1 << N) + 64'd1));

  // d1 lies in [-(2^N-1), 2*(2^N-1)], so at most one correction is needed either way.
  function automatic logic [N:0] reduce_p1(input logic signed [N+1:0] d);
    logic signed [N+2:0] t;
    t = {d[N+1], d};
    if (t < 0) t = t + MOD1;
    if (t >= MOD1) t = t - MOD1;
    return (N+1)'(t);
  endfunction

  // Two end-around folds bring any N+2-bit sum below 2^N; all-ones is the second zero.
  function automatic logic [N-1:0] reduce_m1(input logic [N+1:0] s);
    logic [N:0]   f;
    logic [N-1:0] g;
    f = {1'b0, s[N-1:0]} + {{(N-1){1'b0}}, s[N+1:N]};
    g = f[N-1:0] + {{(N-1){1'b0}}, f[N]};
    return (g == {N{1'b1}}) ? '0 : g;
  endfunction

  logic                  adv1, adv2;
  logic                  vld_p1, vld_p2;
  logic [N-1:0]          h_p0, m_p0, l_p0;
  logic [N+1:0]          s3_p0, s3_p1;
  logic signed [N+1:0]   d1_p0, d1_p1;
  logic                  err_p0, err_p1, err_p2;
  logic [N-1:0]          r2_p1, r2_p2, r3_p2;
  logic [N:0]            r1_p2;

  assign adv2 = !vld_p2 || io.out_ready_in;
  assign adv1 = !vld_p1 || adv2;

  always_comb begin
    h_p0   = io.x_in[3*N-1:2*N];
    m_p0   = io.x_in[2*N-1:N];
    l_p0   = io.x_in[N-1:0];
    s3_p0  = {2'b00, h_p0} + {2'b00, m_p0} + {2'b00, l_p0};
    d1_p0  = $signed({2'b00, h_p0}) + $signed({2'b00, l_p0}) - $signed({2'b00, m_p0});
    err_p0 = (io.x_in >= RANGE_M);
  end

  // Stage 1: digit sums captured from x_in
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      r2_p1  <= '0;
      s3_p1  <= '0;
      d1_p1  <= '0;
      err_p1 <= 1'b0;
    end else if (adv1) begin
      vld_p1 <= io.in_valid_in;
      if (io.in_valid_in) begin
        r2_p1  <= l_p0;
        s3_p1  <= s3_p0;
        d1_p1  <= d1_p0;
        err_p1 <= err_p0;
      end
    end
  end

  // Stage 2: modular reduction, drives the outputs directly
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      r1_p2  <= '0;
      r2_p2  <= '0;
      r3_p2  <= '0;
      err_p2 <= 1'b0;
    end else if (adv2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        r1_p2  <= reduce_p1(d1_p1);
        r2_p2  <= r2_p1;
        r3_p2  <= reduce_m1(s3_p1);
        err_p2 <= err_p1;
      end
    end
  end

  assign io.in_ready_out  = adv1;
  assign io.out_valid_out = vld_p2;
  assign io.r1_out        = r1_p2;
  assign io.r2_out        = r2_p2;
  assign io.r3_out        = r3_p2;
  assign io.range_err_out = err_p2;
endmodule

// File: tb/tb_rns_forward_converter_1025_1024_1023.sv
// Bench for the RNS forward converter: directed corner values, backpressure, reset flush
// and a random stream scored against plain-modulo reference residues.
module tb_rns_forward_converter_1025_1024_1023;
  localparam int N = 10;
  localparam logic [29:0] RANGE_M = 30'd1073740800;

  typedef struct {
    logic [10:0] r1;
    logic [9:0]  r2;
    logic [9:0]  r3;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  rns_forward_converter_1025_1024_1023_if #(.N(N)) io ();

  rns_forward_converter_1025_1024_1023 #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_acc    = 0;
  bit   last_acc = 0;
  bit   stall_prev = 0;
  exp_t held;
  exp_t q[$];

  function automatic exp_t model(input logic [29:0] x);
    exp_t e;
    int unsigned v;
    v     = 32'(x);
    e.r1  = 11'(v % 1025);
    e.r2  = 10'(v % 1024);
    e.r3  = 10'(v % 1023);
    e.err = (v >= 32'd1073740800);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: score outputs and record accepts at the negedge, return at posedge+1.
  task automatic step();
    exp_t e;
    @(negedge clk);
    last_acc = 0;
    if (!rst) begin
      if (stall_prev) begin
        chk("hold_valid", 32'(io.out_valid_out), 32'd1);
        chk("hold_r1", 32'(io.r1_out), 32'(held.r1));
        chk("hold_r2", 32'(io.r2_out), 32'(held.r2));
        chk("hold_r3", 32'(io.r3_out), 32'(held.r3));
        chk("hold_err", 32'(io.range_err_out), 32'(held.err));
      end
      stall_prev = io.out_valid_out && !io.out_ready_in;
      held.r1  = io.r1_out;
      held.r2  = io.r2_out;
      held.r3  = io.r3_out;
      held.err = io.range_err_out;
      if (io.out_valid_out && io.out_ready_in) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'(io.out_valid_out), 32'd0);
        end else begin
          e = q.pop_front();
          chk("sb_r1", 32'(io.r1_out), 32'(e.r1));
          chk("sb_r2", 32'(io.r2_out), 32'(e.r2));
          chk("sb_r3", 32'(io.r3_out), 32'(e.r3));
          chk("sb_err", 32'(io.range_err_out), 32'(e.err));
        end
      end
      if (io.in_valid_in && io.in_ready_out) begin
        q.push_back(model(io.x_in));
        n_acc++;
        last_acc = 1;
      end
    end else begin
      stall_prev = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_check(input logic [29:0] x, input logic [10:0] e1,
                            input logic [9:0] e2, input logic [9:0] e3, input logic ee);
    io.x_in        = x;
    io.in_valid_in = 1'b1;
    step();
    io.in_valid_in = 1'b0;
    chk("lat1_valid", 32'(io.out_valid_out), 32'd0);
    step();
    chk("lat2_valid", 32'(io.out_valid_out), 32'd1);
    chk("dir_r1", 32'(io.r1_out), 32'(e1));
    chk("dir_r2", 32'(io.r2_out), 32'(e2));
    chk("dir_r3", 32'(io.r3_out), 32'(e3));
    chk("dir_err", 32'(io.range_err_out), 32'(ee));
    step();
  endtask

  initial begin
    int base;
    int cyc;
    rst             = 1'b1;
    io.x_in         = '0;
    io.in_valid_in  = 1'b0;
    io.out_ready_in = 1'b1;
    repeat (2) step();
    chk("rst_out_valid", 32'(io.out_valid_out), 32'd0);
    chk("rst_in_ready", 32'(io.in_ready_out), 32'd1);
    chk("rst_r1", 32'(io.r1_out), 32'd0);
    chk("rst_r2", 32'(io.r2_out), 32'd0);
    chk("rst_r3", 32'(io.r3_out), 32'd0);
    chk("rst_err", 32'(io.range_err_out), 32'd0);
    rst = 1'b0;

    send_check(30'd0,          11'd0,    10'd0,    10'd0,    1'b0);
    send_check(30'd1073740799, 11'd1024, 10'd1023, 10'd1022, 1'b0);
    send_check(30'd1023,       11'd1023, 10'd1023, 10'd0,    1'b0);
    send_check(30'd1024,       11'd1024, 10'd0,    10'd1,    1'b0);
    send_check(30'd1073741823, 11'd1023, 10'd1023, 10'd0,    1'b1);
    send_check(30'd1073740800, 11'd0,    10'd0,    10'd0,    1'b1);

    // Backpressure: two accepted, third blocked until the output drains.
    io.out_ready_in = 1'b0;
    io.in_valid_in  = 1'b1;
    io.x_in         = 30'd5;
    step();
    io.x_in = 30'd6;
    step();
    io.x_in = 30'd7;
    chk("bp_in_ready_full", 32'(io.in_ready_out), 32'd0);
    step();
    step();
    chk("bp_in_ready_held", 32'(io.in_ready_out), 32'd0);
    chk("bp_out_valid", 32'(io.out_valid_out), 32'd1);
    chk("bp_r1", 32'(io.r1_out), 32'd5);
    chk("bp_r2", 32'(io.r2_out), 32'd5);
    chk("bp_r3", 32'(io.r3_out), 32'd5);
    chk("bp_queue", 32'(q.size()), 32'd2);
    io.out_ready_in = 1'b1;
    #1;
    chk("bp_in_ready_comb", 32'(io.in_ready_out), 32'd1);
    step();
    io.in_valid_in = 1'b0;
    chk("bp_next_r1", 32'(io.r1_out), 32'd6);
    step();
    chk("bp_last_r1", 32'(io.r1_out), 32'd7);
    step();
    chk("bp_drained", 32'(q.size()), 32'd0);

    // Random stream with random downstream stalls.
    base = n_acc;
    cyc  = 0;
    io.in_valid_in = 1'b0;
    while ((n_acc - base) < 2000 && cyc < 20000) begin
      if (!io.in_valid_in || last_acc) begin
        if ((n_acc - base) + (last_acc ? 0 : 0) >= 2000) io.in_valid_in = 1'b0;
        else io.in_valid_in = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 9) == 0) io.x_in = RANGE_M - 30'd3 + 30'($urandom_range(0, 6));
        else io.x_in = 30'($urandom);
      end
      io.out_ready_in = ($urandom_range(0, 2) != 0);
      step();
      cyc++;
    end
    io.in_valid_in  = 1'b0;
    chk("rand_accepted", 32'(n_acc - base), 32'd2000);
    io.out_ready_in = 1'b1;
    repeat (4) step();
    chk("rand_drained", 32'(q.size()), 32'd0);

    // Reset with both stages full discards everything in flight.
    io.out_ready_in = 1'b0;
    io.in_valid_in  = 1'b1;
    io.x_in         = 30'd100;
    step();
    io.x_in = 30'd200;
    step();
    io.in_valid_in = 1'b0;
    chk("mid_full_valid", 32'(io.out_valid_out), 32'd1);
    chk("mid_full_ready", 32'(io.in_ready_out), 32'd0);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 32'(io.out_valid_out), 32'd0);
    chk("mid_rst_ready", 32'(io.in_ready_out), 32'd1);
    chk("mid_rst_r1", 32'(io.r1_out), 32'd0);
    chk("mid_rst_r2", 32'(io.r2_out), 32'd0);
    chk("mid_rst_r3", 32'(io.r3_out), 32'd0);
    q.delete();
    rst = 1'b0;
    io.out_ready_in = 1'b1;
    repeat (5) begin
      step();
      chk("post_rst_no_output", 32'(io.out_valid_out), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/rns_forward_converter_1025_1024_1023.md
Name: rns_forward_converter_1025_1024_1023

Overview:
- Pipelined binary-to-RNS forward converter for the moduli set {2^N+1, 2^N, 2^N-1}, with N=10 giving {1025, 1024, 1023}.
- Sits directly upstream of the RNS compare/arithmetic blocks. It produces the (x1, x2, x3) residue triples those blocks consume.
- Uses a two-stage valid/ready pipeline with full backpressure.
- Flags inputs at or above the dynamic range M = 1025*1024*1023 = 1073740800.

Parameters:
- N, 10, modulus exponent. Residue widths are N+1, N and N. Binary input width is 3N.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- x_in  input  3N  binary operand
- in_valid_in  input  1  x_in valid
- in_ready_out  output  1  converter can accept x_in this cycle
- r1_out  output  N+1  x mod (2^N+1)
- r2_out  output  N  x mod 2^N
- r3_out  output  N  x mod (2^N-1)
- range_err_out  output  1  x_in was >= (2^N+1)*2^N*(2^N-1)
- out_valid_out  output  1  r*_out and range_err_out valid
- out_ready_in  input  1  downstream accepts this cycle

Behaviour:
- Split x = H*2^(2N) + M*2^N + L, with H, M and L each N bits.
- Residue r2 = L. It is registered in stage 1 and forwarded unchanged through stage 2.
- Residue r3, stage 1: s3 = H+M+L (N+2 bits).
- Residue r3, stage 2: fold s3 with end-around carry (2^N ≡ 1) until < 2^N. A folded result equal to 2^N-1 maps to 0.
- Residue r1, stage 1: d1 = H+L-M as a signed N+2-bit value, since 2^N ≡ -1.
- Residue r1, stage 2: add 2^N+1 if d1 < 0; subtract 2^N+1 if the result is >= 2^N+1. The result is in [0, 2^N].
- range_err: computed combinationally on x_in in stage 1 (x_in >= M constant) and carried down the pipe.
- Out-of-range inputs still produce the correct residues of x_in. The flag is advisory; the value it represents is x_in mod M.
- Pipeline registers: s1_valid and s1 data; s2_valid and s2 data. Outputs are driven directly from stage 2; out_valid_out = s2_valid.
- Stage-2 load enable: adv2 = !s2_valid || out_ready_in. Stage 2 loads from stage 1 when adv2; s2_valid <= s1_valid.
- Stage-1 load enable: adv1 = !s1_valid || adv2. Stage 1 loads from x_in when adv1; s1_valid <= in_valid_in.
- in_ready_out = adv1, which is combinational from out_ready_in. A transfer occurs when in_valid_in && in_ready_out.
- Latency is 2 cycles from accept to out_valid_out with no backpressure. Throughput is 1 per cycle.
- Stalls: when out_valid_out && !out_ready_in, r*_out and range_err_out hold stable.
- With both stages full and out_ready_in low, in_ready_out = 0. The pipe never drops or duplicates data.
- Order is strictly preserved.
- Simultaneous accept and emit in the same cycle is supported with no bubble.
- Reset (synchronous, active-high):
  - s1_valid = s2_valid = 0.
  - out_valid_out = 0, r1_out = r2_out = r3_out = 0, range_err_out = 0, in_ready_out = 1 in the first cycle after reset.
  - Reset mid-operation discards in-flight data. Stage data registers are also cleared, so outputs read 0.
- Data registers load only on their stage enable; they do not toggle while invalid bubbles pass.

Test Plan:
- Reset, then x=0, out_ready=1 -> 2 cycles later out_valid=1 with (r1, r2, r3) = (0, 0, 0) and range_err=0.
- x=1073740799 (M-1) -> (1024, 1023, 1022) and range_err=0. x=1023 -> (1023, 1023, 0). x=1024 -> (1024, 0, 1).
- x=1073741823 (2^30-1) -> (1023, 1023, 0) and range_err=1. x=1073740800 -> (0, 0, 0) and range_err=1.
- Hold out_ready=0 and drive 3 valid inputs (5, 6, 7):
  - Only 5 and 6 are accepted; in_ready=0 thereafter.
  - Outputs hold at 5's residues (5, 5, 5).
  - Raise out_ready: results appear as 5, 6, 7 in consecutive cycles, with 7 then accepted.
- Back-to-back stream of 2000 random 30-bit values with random out_ready:
  - Every output matches the reference residues (mod 1025/1024/1023) in order.
  - range_err matches x >= 1073740800.
  - No loss or duplication.
- Assert rst while both stages are valid -> next cycle out_valid=0 and in_ready=1; no stale result appears afterwards.
